// File: rtl/fetch_dispatch.sv
// fetch_dispatch: instruction fetch/dispatch stage ahead of the per-opcode execute FSMs.
// Owns the PC, fetches 16-bit words over a req/ack handshake, holds them in the IR and
// broadcasts them as fullBitNum until the execute FSMs signal done, then forces one
// all-zero CLEAR cycle so every execute FSM returns to st0.
// Optional feature macro: FD_WATCHDOG_EN (EXEC-cycle watchdog, limit WDOG_MAX).
module fetch_dispatch #(
  parameter int unsigned PC_W     = 8,
  parameter logic [15:0] OP_MASK  = 16'hFFFF,
  parameter int unsigned WDOG_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            pc_inc,
  input  logic            done,
  output logic [15:0]     fullBitNum,
  output logic            exec_valid,
  output logic [15:0]     op_onehot,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  localparam int unsigned IW  = 16;
  localparam int unsigned OPW = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [IW-1:0]   fbn_q, fbn_d;
  logic            ev_q, ev_d;
  logic [IW-1:0]   onehot_q, onehot_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic [OPW-1:0]  op_c;
  logic            wdog_exp_c;

`ifdef FD_WATCHDOG_EN
  // Counter holds (EXEC cycle index - 1); it expires on the WDOG_MAX-th EXEC cycle.
  localparam int unsigned WD_W = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;

  logic [WD_W-1:0] wdog_q, wdog_d;

  // Watchdog count: runs only in EXEC, so it is zero on every EXEC entry.
  always_comb begin
    wdog_d = '0;
    if (state_q == ST_EXEC) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  assign wdog_exp_c = (wdog_q == WD_W'(WDOG_MAX - 1));

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_cfg;

  assign wdog_exp_c      = 1'b0;
  assign unused_wdog_cfg = (WDOG_MAX != 0);
`endif

  assign op_c = ir_q[IW-1:IW-OPW];

  // Next-state and next-output logic; outputs are derived from the next state so the
  // registered copies line up with the state register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_FETCH: begin
        // Only an ack against our own outstanding request completes the fetch.
        if (req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_c == 4'hF) begin
          state_d = ST_HALT;
        end else if (op_c == 4'h0) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end else if (!OP_MASK[op_c]) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (pc_inc) begin
          pc_d = pc_q + PC_W'(1);
        end
        // done on the watchdog limit cycle takes priority over expiry.
        if (done) begin
          state_d = ST_CLEAR;
        end else if (wdog_exp_c) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    req_d    = (state_d == ST_FETCH);
    addr_d   = pc_d;
    ev_d     = (state_d == ST_EXEC);
    fbn_d    = ev_d ? ir_q : '0;
    onehot_d = ev_d ? (IW'(1) << op_c) : '0;
    halted_d = (state_d == ST_HALT);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      fbn_q     <= '0;
      ev_q      <= 1'b0;
      onehot_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      fbn_q     <= fbn_d;
      ev_q      <= ev_d;
      onehot_q  <= onehot_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign fullBitNum = fbn_q;
  assign exec_valid = ev_q;
  assign op_onehot  = onehot_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
